// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_controller_pkg;

  // Width of a MIPS register index (rs/rt/rd fields).
  localparam int REG_W = 5;

  // Value a pipeline register loads when it is flushed into a bubble.
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  // Memory-wait FSM state encoding.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hz_state_e;

  // Enable/flush bundle driving the PC and the four pipeline registers.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
    logic memwb_flush;
  } ctrl_t;

  // Everything advances, no bubbles.
  localparam ctrl_t CTRL_ADVANCE = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
    idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1, memwb_flush: 1'b0
  };

  // Nothing moves (reset and error).
  localparam ctrl_t CTRL_FREEZE = '0;

  // Data memory busy: front of the pipe and MEM hold, WB receives a bubble.
  localparam ctrl_t CTRL_MEM_STALL = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0,
    idex_flush: 1'b0, exmem_en: 1'b0, memwb_en: 1'b1, memwb_flush: 1'b1
  };

  // Taken branch: squash the two younger instructions in IF/ID and ID/EX.
  localparam ctrl_t CTRL_BRANCH = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_en: 1'b1,
    idex_flush: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1, memwb_flush: 1'b0
  };

  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
  localparam ctrl_t CTRL_LOAD_USE = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b1,
    idex_flush: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1, memwb_flush: 1'b0
  };

  // Jump decoded in ID: squash the sequentially fetched instruction.
  localparam ctrl_t CTRL_JUMP = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_en: 1'b1,
    idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1, memwb_flush: 1'b0
  };

  // True when the load in EX writes a register the ID instruction reads.
  // Register $0 is hard-wired to zero and never creates a dependency.
  function automatic logic load_use_hit(
    input logic             ex_mem_read,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt,
    input logic             id_uses_rt
  );
    return ex_mem_read && (ex_rt != '0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter used for stall/flush performance statistics.
// Latency: count reflects an increment one rising edge after inc_i.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch, jump, memory wait.
// Latency: controls are combinational from registered FSM state and current inputs.
// Backpressure: mem_ready=0 holds PC..EX/MEM; timeout freezes the pipe until reset.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_flush,
  output logic             exmem_enable,
  output logic             memwb_enable,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  ctrl_t ctrl;
  logic  load_use;
  logic  mem_stall;
  logic  stall_inc;
  logic  flush_inc;
  logic  timeout_flag;

  assign load_use = load_use_hit(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

  // FSM state and memory-wait counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state, hazard priority resolution and counter increments.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    ctrl         = CTRL_ADVANCE;
    mem_stall    = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    timeout_flag = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_access && !mem_ready) begin
          mem_stall = 1'b1;
          state_d   = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        // The cycle in which mem_ready rises is a normal advancing cycle.
        if (mem_ready) begin
          state_d = ST_RUN;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      ST_ERROR: begin
        ctrl         = CTRL_FREEZE;
        timeout_flag = 1'b1;
      end
      default: begin
        ctrl    = CTRL_FREEZE;
        state_d = ST_RUN;
      end
    endcase

    if ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) begin
      if (mem_stall) begin
        // A taken branch in EX is held and resolves once memory releases.
        ctrl      = CTRL_MEM_STALL;
        stall_inc = 1'b1;
      end else if (ex_branch_taken) begin
        ctrl      = CTRL_BRANCH;
        flush_inc = 1'b1;
      end else if (load_use) begin
        // Jump in ID waits; it is seen again once the bubble has cleared EX.
        ctrl      = CTRL_LOAD_USE;
        stall_inc = 1'b1;
      end else if (id_jump) begin
        ctrl      = CTRL_JUMP;
        flush_inc = 1'b1;
      end
    end

    if (reset) begin
      ctrl         = CTRL_FREEZE;
      timeout_flag = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
    end
  end

  assign pc_enable    = ctrl.pc_en;
  assign ifid_enable  = ctrl.ifid_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_enable  = ctrl.idex_en;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_enable = ctrl.exmem_en;
  assign memwb_enable = ctrl.memwb_en;
  assign memwb_flush  = ctrl.memwb_flush;
  assign mem_timeout  = timeout_flag;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .inc_i (stall_inc),
    .cnt_o (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .inc_i (flush_inc),
    .cnt_o (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized and directed checks of the hazard controller against a behavioural model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled before negedge.
// Backpressure: n/a.
module tb_pipeline_hazard_controller;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 5;
  localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_mem_read, ex_branch_taken, id_jump, mem_access, mem_ready;
  logic pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic exmem_enable, memwb_enable, memwb_flush, mem_timeout;
  logic [TB_CNT_W-1:0] stall_count, flush_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: memory-wait status, error latch and statistics.
  bit m_waiting;
  int m_wait_cycles;
  bit m_error;
  int m_stalls;
  int m_flushes;
  bit m_stall_now;
  bit m_flush_now;
  logic [7:0] exp_ctrl;
  logic exp_to;
  int err_run;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_enable(pc_enable), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
    .idex_enable(idex_enable), .idex_flush(idex_flush),
    .exmem_enable(exmem_enable), .memwb_enable(memwb_enable), .memwb_flush(memwb_flush),
    .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected controls for this cycle, written directly from the hazard rules.
  // Bit order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_en memwb_flush.
  task automatic model_outputs();
    bit hazard_lu;
    bit mstall;
    m_stall_now = 0;
    m_flush_now = 0;
    exp_to      = 0;
    if (reset) begin
      m_waiting = 0; m_wait_cycles = 0; m_error = 0; m_stalls = 0; m_flushes = 0;
      exp_ctrl = 8'b0000_0000;
      return;
    end
    if (m_error) begin
      exp_ctrl = 8'b0000_0000;
      exp_to   = 1;
      return;
    end
    hazard_lu = ex_mem_read && ex_rt != 0 &&
                (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    mstall = m_waiting ? !mem_ready : (mem_access && !mem_ready);
    if (mstall) begin
      exp_ctrl = 8'b0000_0011; m_stall_now = 1;
    end else if (ex_branch_taken) begin
      exp_ctrl = 8'b1111_1110; m_flush_now = 1;
    end else if (hazard_lu) begin
      exp_ctrl = 8'b0001_1110; m_stall_now = 1;
    end else if (id_jump) begin
      exp_ctrl = 8'b1111_0110; m_flush_now = 1;
    end else begin
      exp_ctrl = 8'b1101_0110;
    end
  endtask

  // Advance the model across a rising edge.
  task automatic model_update();
    if (reset || m_error) return;
    if (m_stall_now) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
    if (m_flush_now) m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
    if (m_waiting) begin
      if (mem_ready) begin
        m_waiting = 0; m_wait_cycles = 0;
      end else begin
        m_wait_cycles++;
        if (m_wait_cycles >= TB_TIMEOUT) begin
          m_error = 1; m_waiting = 0;
        end
      end
    end else if (mem_access && !mem_ready) begin
      m_waiting = 1; m_wait_cycles = 0;
    end
  endtask

  // One clock: check the current inputs' outputs, then cross the edge.
  task automatic step();
    model_outputs();
    #3;
    chk("ctrl", {24'd0, pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
                 exmem_enable, memwb_enable, memwb_flush}, {24'd0, exp_ctrl});
    chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, exp_to});
    chk("stall_count", 32'(stall_count), 32'(m_stalls));
    chk("flush_count", 32'(flush_count), 32'(m_flushes));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rt = 0;
    ex_branch_taken = 0; id_jump = 0; mem_access = 0; mem_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    @(posedge clk);
    #1;
    do_reset();

    // Load-use on rs: one stall cycle, then free flow.
    ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_rt = 3; id_uses_rt = 1;
    step();
    chk("lu_stall_cnt", 32'(stall_count), 32'd1);
    ex_mem_read = 0;
    step();

    // Load to $0 never stalls.
    ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_rt = 0;
    step();

    // Load-use via rt only when rt is a source.
    ex_rt = 5; id_rs = 1; id_rt = 5; id_uses_rt = 0;
    step();
    id_uses_rt = 1;
    step();
    idle_inputs();

    // Branch together with load-use: branch wins.
    ex_mem_read = 1; ex_rt = 9; id_rs = 9; ex_branch_taken = 1;
    step();
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    idle_inputs();

    // Load-use with jump: stall wins, no IF/ID flush.
    ex_mem_read = 1; ex_rt = 4; id_rs = 4; id_jump = 1;
    step();
    ex_mem_read = 0;
    step();
    idle_inputs();

    // Three memory wait cycles then release, with a branch pending.
    do_reset();
    mem_access = 1; mem_ready = 0; ex_branch_taken = 1;
    repeat (3) step();
    mem_ready = 1;
    step();
    chk("mem_stall_cnt", 32'(stall_count), 32'd3);
    chk("mem_br_flush", 32'(flush_count), 32'd1);
    idle_inputs();

    // Timeout: memory never answers.
    mem_access = 1; mem_ready = 0;
    repeat (TB_TIMEOUT + 1) step();
    chk("timeout_set", {31'd0, mem_timeout}, 32'd1);
    mem_ready = 1; ex_branch_taken = 1;
    repeat (3) step();
    do_reset();
    chk("timeout_clr", {31'd0, mem_timeout}, 32'd0);
    chk("stall_clr", 32'(stall_count), 32'd0);

    // Jump alone: IF/ID flush only.
    id_jump = 1;
    step();
    idle_inputs();

    // Saturation of both counters.
    ex_mem_read = 1; ex_rt = 7; id_rs = 7;
    repeat (CNT_MAX + 6) step();
    chk("stall_sat", 32'(stall_count), 32'(CNT_MAX));
    idle_inputs();
    id_jump = 1;
    repeat (CNT_MAX + 6) step();
    chk("flush_sat", 32'(flush_count), 32'(CNT_MAX));
    idle_inputs();

    // Randomized traffic with occasional resets.
    err_run = 0;
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 79) == 0) || (err_run > 3);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = ($urandom_range(0, 1) == 1);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      id_jump         = ($urandom_range(0, 5) == 0);
      mem_access      = ($urandom_range(0, 2) == 0);
      mem_ready       = ($urandom_range(0, 2) != 0);
      step();
      err_run = m_error ? err_run + 1 : 0;
    end
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
